systolic_mm_engine: RTL and testbench

Parametrised N×N output-stationary systolic matrix multiplier, the successor to the fixed 4×4 8-bit controller/array pair. It accepts a full A and B operand set via a valid/ready handshake and generates the diagonal skew internally. It runs the PE grid for a fixed, N-derived number of cycles, then streams C out one row per beat under back-pressure. Signed or unsigned arithmetic is selected at elaboration, and accumulators are sized so they never overflow.

---
 rtl/systolic_pkg.sv | 21 ++
 rtl/systolic_pe.sv | 56 +++++
 rtl/systolic_mm_engine.sv | 170 +++++++++++++++++
 tb/tb_systolic_mm_engine.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and elaboration helpers for the systolic matrix-multiply engine.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    OUT
  } state_t;

  // Width of the single FEED/DRAIN cycle counter: it must reach 3N-3.
  function automatic int cnt_w(input int n);
    return $clog2(3 * n);
  endfunction

  // Accumulator width: full product plus enough guard bits for N terms.
  function automatic int acc_w(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// Output-stationary processing element: multiply-accumulate with east/south
// forwarding of the operands through one register each.
module systolic_pe #(
  parameter int DW     = 8,
  parameter int AW     = 18,
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic [AW-1:0] acc
);

  logic        [DW-1:0]   a_p0;
  logic        [DW-1:0]   b_p0;
  logic signed [2*DW-1:0] a_x;
  logic signed [2*DW-1:0] b_x;
  logic signed [2*DW-1:0] prod;
  logic        [AW-1:0]   prod_ext;

  // Extend operands to product width, multiply, then extend the product to AW
  // (AW is assumed wider than 2*DW, which the default derivation guarantees).
  always_comb begin
    if (SIGNED != 0) begin
      a_x = {{DW{a_in[DW-1]}}, a_in};
      b_x = {{DW{b_in[DW-1]}}, b_in};
    end else begin
      a_x = {{DW{1'b0}}, a_in};
      b_x = {{DW{1'b0}}, b_in};
    end
    prod = a_x * b_x;
    if (SIGNED != 0) prod_ext = {{(AW-2*DW){prod[2*DW-1]}}, prod};
    else             prod_ext = {{(AW-2*DW){1'b0}}, prod};
  end

  // Stage p0: operand pass registers and accumulator; clr starts a new job.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      a_p0 <= '0;
      b_p0 <= '0;
      acc  <= '0;
    end else begin
      a_p0 <= a_in;
      b_p0 <= b_in;
      acc  <= acc + prod_ext;
    end
  end

  assign a_out = a_p0;
  assign b_out = b_p0;

endmodule

// File: rtl/systolic_mm_engine.sv
// N x N output-stationary systolic matrix multiplier: captures A and B,
// skews them into the PE grid, then streams C out one row per beat.
module systolic_mm_engine
  import systolic_pkg::*;
#(
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int AW     = acc_w(N, DW),
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*N*DW-1:0]     a_in,
  input  logic [N*N*DW-1:0]     b_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*AW-1:0]       c_row,
  output logic [$clog2(N)-1:0]  out_row,
  output logic                  out_last,
  output logic                  busy
);

  localparam int CW = cnt_w(N);
  localparam int RW = $clog2(N);
  localparam logic [CW-1:0] FEED_LAST  = CW'(2*N-2);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(3*N-3);
  localparam logic [RW-1:0] ROW_LAST   = RW'(N-1);
  localparam logic [RW-1:0] ROW_PENULT = RW'(N-2);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [N*N*DW-1:0]    a_q;
  logic [N*N*DW-1:0]    b_q;
  logic                 accept;
  logic [DW-1:0]        west  [N];
  logic [DW-1:0]        north [N];
  logic [DW-1:0]        a_h   [N][N+1];
  logic [DW-1:0]        b_v   [N+1][N];
  logic [AW-1:0]        acc   [N][N];
  logic                 pass_unused;

  assign accept = in_valid && in_ready;

  // Operand registers hold the accepted job for the whole FEED phase.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a_in;
      b_q <= b_in;
    end
  end

  // Diagonal skew: slot cnt drives A[i][cnt-i] west and B[cnt-j][j] north.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      west[i]  = '0;
      north[i] = '0;
    end
    if (state == FEED) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(cnt) == i + k) begin
            west[i]  = a_q[(i*N+k)*DW +: DW];
            north[i] = b_q[(k*N+i)*DW +: DW];
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_edge
    assign a_h[gi][0] = west[gi];
    assign b_v[0][gi] = north[gi];
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      systolic_pe #(
        .DW     (DW),
        .AW     (AW),
        .SIGNED (SIGNED)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .a_in  (a_h[gi][gj]),
        .b_in  (b_v[gi][gj]),
        .a_out (a_h[gi][gj+1]),
        .b_out (b_v[gi+1][gj]),
        .acc   (acc[gi][gj])
      );
    end
  end

  // Operands leaving the far edge of the grid are intentionally dropped.
  always_comb begin
    pass_unused = 1'b0;
    for (int i = 0; i < N; i++) begin
      pass_unused = pass_unused ^ (^a_h[i][N]) ^ (^b_v[N][i]);
    end
  end

  // Result row mux; accumulators are registers so c_row is glitch-free of inputs.
  always_comb begin
    c_row = '0;
    for (int j = 0; j < N; j++) begin
      c_row[j*AW +: AW] = acc[out_row][j];
    end
  end

  // Control FSM with a single cycle counter spanning FEED and DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_row   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= FEED;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        FEED: begin
          cnt <= cnt + 1'b1;
          if (cnt == FEED_LAST) state <= DRAIN;
        end
        DRAIN: begin
          cnt <= cnt + 1'b1;
          if (cnt == DRAIN_LAST) begin
            state     <= OUT;
            cnt       <= '0;
            out_valid <= 1'b1;
            out_row   <= '0;
            out_last  <= 1'b0;
          end
        end
        OUT: begin
          if (out_ready) begin
            if (out_row == ROW_LAST) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_row   <= '0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              out_row  <= out_row + 1'b1;
              out_last <= (out_row == ROW_PENULT);
            end
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Self-checking bench: an unsigned and a signed engine share the stimulus and
// are compared against a plain matrix-product reference model.
module tb_systolic_mm_engine;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 2*DW + $clog2(N);
  localparam int RW = $clog2(N);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              out_ready;
  logic [N*N*DW-1:0] a_in;
  logic [N*N*DW-1:0] b_in;

  logic              in_ready_u,  in_ready_s;
  logic              out_valid_u, out_valid_s;
  logic [N*AW-1:0]   c_row_u,     c_row_s;
  logic [RW-1:0]     out_row_u,   out_row_s;
  logic              out_last_u,  out_last_s;
  logic              busy_u,      busy_s;

  int checks = 0;
  int errors = 0;

  int            am [N][N];
  int            bm [N][N];
  logic [AW-1:0] eu [N][N];
  logic [AW-1:0] es [N][N];
  logic [AW-1:0] gu [N][N];
  logic [AW-1:0] gs [N][N];

  always #5 clk = ~clk;

  systolic_mm_engine #(.N(N), .DW(DW), .AW(AW), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid_u), .out_ready(out_ready),
    .c_row(c_row_u), .out_row(out_row_u), .out_last(out_last_u), .busy(busy_u)
  );

  systolic_mm_engine #(.N(N), .DW(DW), .AW(AW), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid_s), .out_ready(out_ready),
    .c_row(c_row_s), .out_row(out_row_s), .out_last(out_last_s), .busy(busy_s)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= (1 << (DW-1))) ? v - (1 << DW) : v;
  endfunction

  // Reference: C = A*B with plain integer arithmetic, reduced mod 2^AW.
  task automatic model();
    longint su, ss;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        su = 0;
        ss = 0;
        for (int k = 0; k < N; k++) begin
          su += longint'(am[i][k]) * longint'(bm[k][j]);
          ss += longint'(sx(am[i][k])) * longint'(sx(bm[k][j]));
        end
        eu[i][j] = AW'(su);
        es[i][j] = AW'(ss);
      end
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        am[i][k] = int'($urandom_range(0, (1 << DW) - 1));
        bm[i][k] = int'($urandom_range(0, (1 << DW) - 1));
      end
  endtask

  // Called at a negedge: pulse rst for one edge and check the idle outputs.
  task automatic reset_check(input string tag);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk({tag, "_out_valid"}, 128'(out_valid_u), 128'(0));
    chk({tag, "_in_ready"},  128'(in_ready_u),  128'(1));
    chk({tag, "_busy"},      128'(busy_u),      128'(0));
    chk({tag, "_row_last"},  128'({out_row_u, out_last_u}), 128'(0));
    chk({tag, "_c_row"},     128'(c_row_u),     128'(0));
    chk({tag, "_sgn_state"}, 128'({c_row_s, out_valid_s, in_ready_s, busy_s}), 128'(3'b010));
  endtask

  // One job, entered at a negedge. mode: 0 ready high, 1 pattern 1,0,0, 2 random.
  task automatic run_job(input int mode, input bit hold, input bit chained,
                         input int abort_feed, input int abort_beat);
    int waits, lat, row, pat, guard;
    bit stalled;
    logic [N*AW-1:0] er_u, er_s, prev_u, prev_s;
    logic [RW-1:0]   prev_r;
    model();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        a_in[(i*N+k)*DW +: DW] = DW'(am[i][k]);
        b_in[(i*N+k)*DW +: DW] = DW'(bm[i][k]);
      end
    in_valid = 1'b1;
    waits = 0;
    while (!in_ready_u && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (chained) chk("chain_wait", 128'(waits), 128'(0));
    if (!in_ready_u) begin
      chk("accept_timeout", 128'(in_ready_u), 128'(1));
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
    for (int b = 0; b < N*N; b++) begin
      a_in[b*DW +: DW] = DW'($urandom);
      b_in[b*DW +: DW] = DW'($urandom);
    end
    chk("feed_busy_ready", 128'({busy_u, in_ready_u}), 128'(2'b10));
    if (abort_feed > 0) begin
      repeat (abort_feed) @(negedge clk);
      reset_check("rst_feed");
      return;
    end
    lat = 0;
    while (!out_valid_u && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("first_valid_latency", 128'(lat), 128'(3*N-2));
    row = 0; pat = 0; guard = 0; stalled = 1'b0;
    prev_u = '0; prev_s = '0; prev_r = '0;
    while (row < N && guard < 200) begin
      if (stalled) begin
        chk("stall_c_row",   128'(c_row_u), 128'(prev_u));
        chk("stall_c_row_s", 128'(c_row_s), 128'(prev_s));
        chk("stall_row_vld", 128'({out_row_u, out_valid_u}), 128'({prev_r, 1'b1}));
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (pat % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      pat++;
      if (out_valid_u && out_ready) begin
        for (int j = 0; j < N; j++) begin
          er_u[j*AW +: AW] = eu[row][j];
          er_s[j*AW +: AW] = es[row][j];
          gu[row][j] = c_row_u[j*AW +: AW];
          gs[row][j] = c_row_s[j*AW +: AW];
        end
        chk("beat_row",   128'(out_row_u),  128'(row));
        chk("beat_last",  128'(out_last_u), 128'(row == N-1));
        chk("beat_c_row", 128'(c_row_u),    128'(er_u));
        chk("beat_c_row_signed", 128'(c_row_s), 128'(er_s));
        chk("beat_in_ready", 128'(in_ready_u), 128'(0));
        chk("beat_sgn_ctrl",
            128'({out_valid_s, out_row_s, out_last_s, in_ready_s, busy_s}),
            128'({1'b1, RW'(row), row == N-1, 1'b0, 1'b1}));
        row++;
      end
      stalled = out_valid_u && !out_ready;
      prev_u  = c_row_u;
      prev_s  = c_row_s;
      prev_r  = out_row_u;
      @(posedge clk);
      if (abort_beat > 0 && row == abort_beat) begin
        @(negedge clk);
        reset_check("rst_out");
        return;
      end
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    if (row < N) chk("beats_timeout", 128'(row), 128'(N));
    chk("done_idle", 128'({in_ready_u, busy_u, out_valid_u}), 128'(3'b100));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready",  128'(in_ready_u),  128'(1));
    chk("reset_out_valid", 128'(out_valid_u), 128'(0));
    chk("reset_busy",      128'(busy_u),      128'(0));
    chk("reset_row_last",  128'({out_row_u, out_last_u}), 128'(0));
    chk("reset_c_row",     128'(c_row_u),     128'(0));

    // A = 1..16, B = 17..32, both row-major
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        am[i][k] = i*N + k + 1;
        bm[i][k] = 17 + i*N + k;
      end
    run_job(0, 1'b0, 1'b0, 0, 0);
    chk("c00", 128'(gu[0][0]), 128'(250));
    chk("c01", 128'(gu[0][1]), 128'(260));
    chk("c02", 128'(gu[0][2]), 128'(270));
    chk("c03", 128'(gu[0][3]), 128'(280));
    chk("c33", 128'(gu[3][3]), 128'(1528));

    // identity B, random A
    fill_random();
    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++) bm[k][j] = (k == j) ? 1 : 0;
    run_job(2, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) chk("identity", 128'(gu[i][j]), 128'(am[i][j]));

    // overflow bounds
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin am[i][k] = 255; bm[i][k] = 255; end
    run_job(0, 1'b0, 1'b0, 0, 0);
    chk("max_unsigned", 128'(gu[2][1]), 128'(260100));
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin am[i][k] = 128; bm[i][k] = 128; end
    run_job(0, 1'b0, 1'b0, 0, 0);
    chk("min_signed", 128'(gs[1][2]), 128'(65536));

    // back-pressure 1,0,0 pattern
    fill_random();
    run_job(1, 1'b0, 1'b0, 0, 0);

    // in_valid held across two back-to-back jobs
    fill_random();
    run_job(0, 1'b1, 1'b0, 0, 0);
    fill_random();
    run_job(0, 1'b0, 1'b1, 0, 0);

    // reset mid-FEED, then a clean job
    fill_random();
    run_job(0, 1'b0, 1'b0, 3, 0);
    fill_random();
    run_job(2, 1'b0, 1'b0, 0, 0);

    // reset mid-OUT after the first beat, then a clean job
    fill_random();
    run_job(0, 1'b0, 1'b0, 0, 1);
    fill_random();
    run_job(1, 1'b0, 1'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
